// File: rtl/register_file_pkg.sv
// ============================================================================
//  Module      : register_file_pkg
//  Description : Shared types and default sizing for register_file_n.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package register_file_pkg;

    // Default sizing matches the 8-bit processor's file
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    // Clear sequencer states
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/register_file_n_if.sv
// ============================================================================
//  Module      : register_file_n_if
//  Description : Bus bundle between the decode stage (master) and the
//                register file (slave).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface register_file_n_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 2
);
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] rs0;
    logic [ADDR_W-1:0] rs1;
    logic              regWrite;
    logic [WIDTH-1:0]  writeData;
    logic              clear;
    logic [WIDTH-1:0]  outData0;
    logic [WIDTH-1:0]  outData1;
    logic              busy;

    modport master (
        output rd, rs0, rs1, regWrite, writeData, clear,
        input  outData0, outData1, busy
    );

    modport slave (
        input  rd, rs0, rs1, regWrite, writeData, clear,
        output outData0, outData1, busy
    );
endinterface

`default_nettype wire

// File: rtl/register_file_clear_fsm.sv
// ============================================================================
//  Module      : register_file_clear_fsm
//  Description : Clear sweep sequencer. Walks the sweep address over every
//                register, one per cycle, and holds busy one extra cycle
//                after the last register is zeroed.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module register_file_clear_fsm
    import register_file_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_clear,
    output logic                   o_busy,
    output logic [ADDR_W-1:0]      o_sweep_addr,
    output logic                   o_sweep_we
);

    localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(DEPTH - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_busy;

    // Sequencer: a clear is only accepted once busy has dropped, so a pulse
    // during the sweep (or its trailing busy cycle) never restarts it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_clear && !r_busy) begin
                        r_state <= ST_CLEAR;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (r_cnt == C_LAST) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + ADDR_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy       = r_busy;
    assign o_sweep_addr = r_cnt;
    assign o_sweep_we   = (r_state == ST_CLEAR);

endmodule

`default_nettype wire

// File: rtl/register_file_n.sv
// ============================================================================
//  Module      : register_file_n
//  Description : DEPTH x WIDTH register file, two combinational read ports,
//                one synchronous write port and a multi-cycle clear sweep.
//                Optional same-cycle write-to-read bypass under the macro
//                REGFILE_BYPASS_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module register_file_n
    import register_file_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  wire logic            clk,
    input  wire logic            rst,
    register_file_n_if.slave     bus
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]  r_mem [DEPTH];

    logic              w_busy;
    logic [ADDR_W-1:0] w_sweep_addr;
    logic              w_sweep_we;
    logic              w_clear_take;
    logic              w_user_we;
    logic [WIDTH-1:0]  w_rd0;
    logic [WIDTH-1:0]  w_rd1;

    register_file_clear_fsm #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (bus.clear),
        .o_busy       (w_busy),
        .o_sweep_addr (w_sweep_addr),
        .o_sweep_we   (w_sweep_we)
    );

    // A clear accepted this cycle drops a simultaneous user write; sweep
    // writes always own the array while the sequencer is in CLEAR
    assign w_clear_take = bus.clear && !w_busy;
    assign w_user_we    = bus.regWrite && !w_sweep_we && !w_clear_take;

    // Storage: sweep zeroing has priority over user writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_sweep_we) begin
            r_mem[w_sweep_addr] <= '0;
        end else if (w_user_we) begin
            r_mem[bus.rd] <= bus.writeData;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic w_byp;

    // Forward the pending write only when it is really going to land and
    // the file is not busy
    assign w_byp = w_user_we && !w_busy;
    assign w_rd0 = (w_byp && (bus.rs0 == bus.rd)) ? bus.writeData : r_mem[bus.rs0];
    assign w_rd1 = (w_byp && (bus.rs1 == bus.rd)) ? bus.writeData : r_mem[bus.rs1];
`else
    assign w_rd0 = r_mem[bus.rs0];
    assign w_rd1 = r_mem[bus.rs1];
`endif

    assign bus.outData0 = w_rd0;
    assign bus.outData1 = w_rd1;
    assign bus.busy     = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_register_file_n.sv
// ============================================================================
//  Module      : tb_register_file_n
//  Description : Directed self-checking bench for register_file_n at
//                WIDTH=8, DEPTH=4.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_register_file_n;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
    localparam int C_TIMEOUT = 100000;

`ifdef REGFILE_BYPASS_EN
    localparam bit C_BYP = 1'b1;
`else
    localparam bit C_BYP = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    logic r_done;

    register_file_n_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    register_file_n #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_both(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
        bus.rs0 = a0;
        bus.rs1 = a1;
        #1;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
        bus.rd        = a;
        bus.writeData = d;
        bus.regWrite  = 1'b1;
        tick();
        bus.regWrite  = 1'b0;
    endtask

    initial begin
        r_done = 1'b0;
        #(C_TIMEOUT);
        if (!r_done) begin
            n_fail++;
            $error("FAIL timeout: directed sequence did not complete");
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        bus.rd = '0; bus.rs0 = '0; bus.rs1 = '0;
        bus.regWrite = 1'b0; bus.writeData = '0; bus.clear = 1'b0;

        // ---------------- reset ----------------
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("reset_busy", WIDTH'(bus.busy), 8'h00);
        for (int a = 0; a < DEPTH; a++) begin
            rd_both(ADDR_W'(a), ADDR_W'(DEPTH - 1 - a));
            chk("reset_rd0", bus.outData0, 8'h00);
            chk("reset_rd1", bus.outData1, 8'h00);
        end

        // ---------------- basic writes / dual read ----------------
        wr(2'd1, 8'hA5);
        wr(2'd2, 8'h3C);
        rd_both(2'd1, 2'd2);
        chk("wr_r1", bus.outData0, 8'hA5);
        chk("wr_r2", bus.outData1, 8'h3C);
        rd_both(2'd2, 2'd2);
        chk("same_addr0", bus.outData0, 8'h3C);
        chk("same_addr1", bus.outData1, 8'h3C);

        // ---------------- same-cycle read of written register ----------------
        bus.rd = 2'd3; bus.writeData = 8'h7E; bus.regWrite = 1'b1;
        rd_both(2'd3, 2'd3);
        chk("byp_same_cycle", bus.outData0, (C_BYP ? 8'h7E : 8'h00));
        chk("byp_same_cycle1", bus.outData1, (C_BYP ? 8'h7E : 8'h00));
        tick();
        bus.regWrite = 1'b0;
        #1;
        chk("wr_r3_next", bus.outData0, 8'h7E);

        // ---------------- clear sweep ----------------
        wr(2'd0, 8'h11); wr(2'd1, 8'h22); wr(2'd2, 8'h33); wr(2'd3, 8'h44);
        bus.clear = 1'b1;
        tick();                                   // E0
        bus.clear = 1'b0;
        rd_both(2'd0, 2'd3);
        chk("clr_e0_busy", WIDTH'(bus.busy), 8'h01);
        chk("clr_e0_r0", bus.outData0, 8'h11);
        bus.rd = 2'd0; bus.writeData = 8'hFF; bus.regWrite = 1'b1;
        tick();                                   // E0+1
        bus.regWrite = 1'b0;
        bus.clear = 1'b1;                         // second clear while busy
        rd_both(2'd0, 2'd3);
        chk("clr_e1_busy", WIDTH'(bus.busy), 8'h01);
        chk("clr_e1_r0", bus.outData0, 8'h00);
        chk("clr_e1_r3", bus.outData1, 8'h44);
        rd_both(2'd1, 2'd2);
        chk("clr_e1_r1", bus.outData0, 8'h22);
        tick();                                   // E0+2
        bus.clear = 1'b0;
        rd_both(2'd1, 2'd2);
        chk("clr_e2_busy", WIDTH'(bus.busy), 8'h01);
        chk("clr_e2_r1", bus.outData0, 8'h00);
        chk("clr_e2_r2", bus.outData1, 8'h33);
        tick();                                   // E0+3
        rd_both(2'd2, 2'd3);
        chk("clr_e3_busy", WIDTH'(bus.busy), 8'h01);
        chk("clr_e3_r2", bus.outData0, 8'h00);
        chk("clr_e3_r3", bus.outData1, 8'h44);
        tick();                                   // E0+4
        rd_both(2'd0, 2'd3);
        chk("clr_e4_busy", WIDTH'(bus.busy), 8'h01);
        chk("clr_e4_r3", bus.outData1, 8'h00);
        chk("clr_e4_r0_nowrite", bus.outData0, 8'h00);
        tick();                                   // E0+5
        chk("clr_e5_busy", WIDTH'(bus.busy), 8'h00);
        tick(); tick();
        chk("no_restart_busy", WIDTH'(bus.busy), 8'h00);

        // ---------------- clear wins over same-cycle write ----------------
        wr(2'd1, 8'h55);
        bus.clear = 1'b1; bus.rd = 2'd1; bus.writeData = 8'h99; bus.regWrite = 1'b1;
        tick();
        bus.clear = 1'b0; bus.regWrite = 1'b0;
        rd_both(2'd1, 2'd1);
        chk("clr_wr_drop_r1", bus.outData0, 8'h55);
        for (int k = 0; k < DEPTH + 1; k++) tick();
        rd_both(2'd1, 2'd0);
        chk("clr_wr_busy_done", WIDTH'(bus.busy), 8'h00);
        chk("clr_wr_r1_zero", bus.outData0, 8'h00);

        // ---------------- reset mid-sweep ----------------
        wr(2'd2, 8'h66);
        wr(2'd3, 8'h77);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        tick();
        chk("mid_busy_pre", WIDTH'(bus.busy), 8'h01);
        rst = 1'b1;
        rd_both(2'd2, 2'd3);
        chk("mid_rst_busy", WIDTH'(bus.busy), 8'h00);
        chk("mid_rst_r2", bus.outData0, 8'h00);
        chk("mid_rst_r3", bus.outData1, 8'h00);
        rst = 1'b0;
        wr(2'd3, 8'h5A);
        rd_both(2'd3, 2'd2);
        chk("post_rst_wr", bus.outData0, 8'h5A);
        chk("post_rst_busy", WIDTH'(bus.busy), 8'h00);

        r_done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
